// File: rtl/mp_reduce_sub.sv
// Limb-serial conditional subtraction: result = X mod M for X < 2M, one LIMB-bit slice per cycle.
// Optional macro REDUCE_TWOPASS_EN runs a second SUB/SEL pass so that X < 3M is accepted.
module mp_reduce_sub #(
  parameter int WIDTH = 1027,
  parameter int LIMB  = 103
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH:0]   in_x,
  input  logic [WIDTH-1:0] in_m,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [1:0]       dbg_state
);

  // Handshake: start is sampled only in IDLE; done is a one-cycle pulse with result valid,
  // result then holds until the next done; busy covers the operation through the done cycle.

  localparam int NLIMB  = (WIDTH + LIMB) / LIMB;
  localparam int PW     = NLIMB * LIMB;
  localparam int LAST_W = WIDTH + 1 - (NLIMB - 1) * LIMB;
  localparam int CW     = $clog2(NLIMB + 1);
  localparam logic [LIMB-1:0] LAST_MASK = {LIMB{1'b1}} >> (LIMB - LAST_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    SEL  = 2'd2
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [WIDTH-1:0] x_reg;
  logic [PW-1:0]    d_reg;
  logic [PW-1:0]    m_reg;
`ifdef REDUCE_TWOPASS_EN
  logic             second;
`endif

  logic             last;
  logic [LIMB-1:0]  mask;
  logic [LIMB-1:0]  m_inv;
  logic [LIMB:0]    sum;
  logic [LIMB-1:0]  diff;
  logic             c_out;
  logic [WIDTH-1:0] pick;

  assign dbg_state = state;

  // Shift registers are padded to NLIMB*LIMB with zeros; the last limb is masked to its real
  // width so the padding never feeds the borrow chain.
  always_comb begin
    last  = (cnt == CW'(NLIMB - 1));
    mask  = last ? LAST_MASK : {LIMB{1'b1}};
    m_inv = ~m_reg[LIMB-1:0] & mask;
    sum   = {1'b0, d_reg[LIMB-1:0]} + {1'b0, m_inv} + {{LIMB{1'b0}}, carry};
    c_out = last ? sum[LAST_W] : sum[LIMB];
    diff  = sum[LIMB-1:0] & mask;
    pick  = carry ? d_reg[WIDTH-1:0] : x_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      x_reg  <= '0;
      d_reg  <= '0;
      m_reg  <= '0;
`ifdef REDUCE_TWOPASS_EN
      second <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      busy <= (state != IDLE);
      case (state)
        IDLE: begin
          if (start) begin
            x_reg <= in_x[WIDTH-1:0];
            d_reg <= PW'(in_x);
            m_reg <= PW'(in_m);
            carry <= 1'b1;
            cnt   <= '0;
            state <= SUB;
          end
        end
        SUB: begin
          d_reg <= {diff, d_reg[PW-1:LIMB]};
          m_reg <= {m_reg[LIMB-1:0], m_reg[PW-1:LIMB]};
          carry <= c_out;
          cnt   <= cnt + 1'b1;
          if (last) state <= SEL;
        end
        SEL: begin
`ifdef REDUCE_TWOPASS_EN
          // First pass feeds its selection straight back; Mreg has rotated back into place.
          if (!second) begin
            x_reg  <= pick;
            d_reg  <= PW'(pick);
            carry  <= 1'b1;
            cnt    <= '0;
            second <= 1'b1;
            state  <= SUB;
          end else begin
            result <= pick;
            done   <= 1'b1;
            second <= 1'b0;
            state  <= IDLE;
          end
`else
          result <= pick;
          done   <= 1'b1;
          state  <= IDLE;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mp_reduce_sub.sv
// Directed bench for mp_reduce_sub: reset, reduction cases, limb borrows, back-to-back and mid-op reset.
// Follows REDUCE_TWOPASS_EN the same way the design does.
module tb_mp_reduce_sub;

  localparam int W  = 1027;
  localparam int L  = 103;
  localparam int NL = 10;
`ifdef REDUCE_TWOPASS_EN
  localparam int LAT = 2 * NL + 2;
`else
  localparam int LAT = NL + 1;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W:0]   in_x;
  logic [W-1:0] in_m;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic [1:0]   dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  mp_reduce_sub #(.WIDTH(W), .LIMB(L)) dut (
    .clk(clk), .rst(rst), .start(start), .in_x(in_x), .in_m(in_m),
    .busy(busy), .done(done), .result(result), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  function automatic logic [W:0] pow2(input int n);
    logic [W:0] v;
    v = '0;
    v[n] = 1'b1;
    return v;
  endfunction

  function automatic string show(input logic [W-1:0] v);
    return $sformatf("%h..%h", v[W-1:W-64], v[127:0]);
  endfunction

  // Drives one operation from an idle DUT and reports result, latency and busy cycles.
  task automatic do_op(input logic [W:0] x, input logic [W-1:0] m,
                       output logic [W-1:0] res, output int lat, output int busy_n);
    @(negedge clk);
    start = 1'b1;
    in_x  = x;
    in_m  = m;
    @(posedge clk);
    #1;
    start = 1'b0;
    in_x  = '1;
    in_m  = '1;
    lat = -1;
    busy_n = 0;
    res = 'x;
    for (int i = 1; i <= 3 * LAT && lat < 0; i++) begin
      @(posedge clk);
      #1;
      if (busy) busy_n++;
      if (done) begin
        lat = i;
        res = result;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; in_x = '0; in_m = '0;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      #1;
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b exp 0", busy); end
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b exp 0", done); end
      n_cmp++; if (result !== '0) begin n_err++; $display("FAIL reset_result: got %s exp 0", show(result)); end
    end
    n_cmp++; if (dbg_state !== 2'd0) begin n_err++; $display("FAIL reset_state: got %0d exp 0", dbg_state); end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL idle_outputs: got busy=%b done=%b exp 0/0", busy, done); end
  endtask

  task automatic test_basic;
    logic [W-1:0] m, res;
    int lat, bn;
    m = W'(pow2(1026) + (W+1)'(3));
    do_op({1'b0, m} + (W+1)'(5), m, res, lat, bn);
    n_cmp++; if (res !== W'(5)) begin n_err++; $display("FAIL basic_result: got %s exp %s", show(res), show(W'(5))); end
    n_cmp++; if (lat !== LAT) begin n_err++; $display("FAIL basic_latency: got %0d exp %0d", lat, LAT); end
    n_cmp++; if (bn !== LAT) begin n_err++; $display("FAIL basic_busy_cycles: got %0d exp %0d", bn, LAT); end
    @(posedge clk);
    #1;
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL done_single_pulse: got %b exp 0", done); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL busy_after_done: got %b exp 0", busy); end
    n_cmp++; if (result !== W'(5)) begin n_err++; $display("FAIL result_held: got %s exp %s", show(result), show(W'(5))); end
  endtask

  task automatic test_select;
    logic [W-1:0] m, res, exp;
    int lat, bn;
    m = W'(pow2(1026) + (W+1)'(3));
    exp = m - W'(1);
    do_op({1'b0, m} - (W+1)'(1), m, res, lat, bn);
    n_cmp++; if (res !== exp) begin n_err++; $display("FAIL below_m: got %s exp %s", show(res), show(exp)); end
    do_op({1'b0, m}, m, res, lat, bn);
    n_cmp++; if (res !== '0) begin n_err++; $display("FAIL equal_m: got %s exp 0", show(res)); end
    n_cmp++; if (lat !== LAT) begin n_err++; $display("FAIL equal_m_latency: got %0d exp %0d", lat, LAT); end
    m = W'(pow2(1026) + (W+1)'(1));
    exp = W'(pow2(1026));
    do_op(({1'b0, m} << 1) - (W+1)'(1), m, res, lat, bn);
    n_cmp++; if (res !== exp) begin n_err++; $display("FAIL two_m_minus_1: got %s exp %s", show(res), show(exp)); end
  endtask

  task automatic test_boundaries;
    logic [W-1:0] m, res, exp;
    logic [W:0] x;
    int lat, bn;
    do_op('0, W'(12345), res, lat, bn);
    n_cmp++; if (res !== '0) begin n_err++; $display("FAIL x_zero: got %s exp 0", show(res)); end
    x = pow2(W) | (W+1)'(64'h0123_4567_89ab_cdef);
    exp = W'(64'h0123_4567_89ab_cdef);
    do_op(x, '0, res, lat, bn);
    n_cmp++; if (res !== exp) begin n_err++; $display("FAIL m_zero: got %s exp %s", show(res), show(exp)); end
    exp = W'(pow2(103)) - W'(1);
    do_op(pow2(103), W'(1), res, lat, bn);
    n_cmp++; if (res !== exp) begin n_err++; $display("FAIL limb_borrow: got %s exp %s", show(res), show(exp)); end
    m = W'(pow2(1026));
`ifdef REDUCE_TWOPASS_EN
    exp = '0;
`else
    exp = W'(pow2(1026));
`endif
    do_op(pow2(W), m, res, lat, bn);
    n_cmp++; if (res !== exp) begin n_err++; $display("FAIL top_bit_only: got %s exp %s", show(res), show(exp)); end
  endtask

  task automatic test_two_m_plus_7;
    logic [W-1:0] m, res, exp;
    int lat, bn;
    m = W'(pow2(1026) + (W+1)'(3));
`ifdef REDUCE_TWOPASS_EN
    exp = W'(7);
`else
    exp = m + W'(7);
`endif
    do_op(({1'b0, m} << 1) + (W+1)'(7), m, res, lat, bn);
    n_cmp++; if (res !== exp) begin n_err++; $display("FAIL two_m_plus_7: got %s exp %s", show(res), show(exp)); end
    n_cmp++; if (lat !== LAT) begin n_err++; $display("FAIL two_m_plus_7_latency: got %0d exp %0d", lat, LAT); end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] m, exp;
    logic [W:0] x;
    int next_acc, due, n_acc, n_done;
    logic [31:0] kk;
    m = W'(pow2(1026) + (W+1)'(3));
    next_acc = 0; due = -1; n_acc = 0; n_done = 0;
    in_m = m;
    for (int k = 0; k < 30 + 2 * LAT; k++) begin
      kk = k;
      @(negedge clk);
      if (k < 30) begin
        if (kk[2]) begin
          x = {1'b0, m} + (W+1)'(k * 1000 + 1);
          exp = W'(k * 1000 + 1);
        end else begin
          x = (W+1)'(k * 7);
          exp = W'(k * 7);
        end
        start = 1'b1;
        in_x = x;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      n_cmp++; if (done !== (k == due)) begin n_err++; $display("FAIL b2b_done_k%0d: got %b exp %b", k, done, (k == due)); end
      if (done) begin
        n_done++;
        if (exp_q.size() > 0) begin
          n_cmp++;
          if (result !== exp_q[0]) begin n_err++; $display("FAIL b2b_result_k%0d: got %s exp %s", k, show(result), show(exp_q[0])); end
          void'(exp_q.pop_front());
        end
      end
      if (k < 30 && k == next_acc) begin
        exp_q.push_back(exp);
        n_acc++;
        due = k + LAT;
        next_acc = k + LAT + 1;
      end
    end
    start = 1'b0;
    n_cmp++; if (n_done !== n_acc) begin n_err++; $display("FAIL b2b_done_count: got %0d exp %0d", n_done, n_acc); end
  endtask

  task automatic test_mid_reset;
    logic [W-1:0] m, res;
    int lat, bn, n_done;
    m = W'(pow2(1026) + (W+1)'(3));
    @(negedge clk);
    start = 1'b1;
    in_x = {1'b0, m} + (W+1)'(5);
    in_m = m;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b exp 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL midrst_done: got %b exp 0", done); end
    n_cmp++; if (result !== '0) begin n_err++; $display("FAIL midrst_result: got %s exp 0", show(result)); end
    @(negedge clk);
    rst = 1'b0;
    n_done = 0;
    for (int i = 0; i < LAT + 4; i++) begin
      @(posedge clk);
      #1;
      if (done) n_done++;
    end
    n_cmp++; if (n_done !== 0) begin n_err++; $display("FAIL midrst_no_done: got %0d exp 0", n_done); end
    do_op({1'b0, m} + (W+1)'(9), m, res, lat, bn);
    n_cmp++; if (res !== W'(9)) begin n_err++; $display("FAIL post_rst_result: got %s exp %s", show(res), show(W'(9))); end
    n_cmp++; if (lat !== LAT) begin n_err++; $display("FAIL post_rst_latency: got %0d exp %0d", lat, LAT); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_select;
    test_boundaries;
    test_two_m_plus_7;
    test_back_to_back;
    repeat (2) @(posedge clk);
    test_mid_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
